// File: rtl/exec_datapath_pkg.sv
// Shared opcode/funct constants, FSM states and the internal ALU command encoding
// for the multi-cycle execute datapath.
package exec_datapath_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_XOR = 6'h26;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [1:0] {ST_IDLE, ST_DECODE, ST_EXEC, ST_WB} state_e;

  typedef enum logic [2:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLT, ALU_PC4, ALU_NONE
  } alu_cmd_e;

  typedef enum logic [1:0] {OPB_REG, OPB_SEXT, OPB_ZEXT} opb_sel_e;
  typedef enum logic [1:0] {DST_NONE, DST_RD, DST_RT, DST_LINK} dst_sel_e;

  typedef struct packed {
    alu_cmd_e cmd;
    opb_sel_e opb;
    dst_sel_e dst;
    logic     ovf_en;
    logic     illegal;
  } dec_t;

  function automatic dec_t decode(input logic [5:0] op, input logic [5:0] funct);
    dec_t d;
    d.cmd     = ALU_NONE;
    d.opb     = OPB_REG;
    d.dst     = DST_NONE;
    d.ovf_en  = 1'b0;
    d.illegal = 1'b0;
    case (op)
      OP_RTYPE: begin
        d.dst = DST_RD;
        case (funct)
          FN_ADD: begin d.cmd = ALU_ADD; d.ovf_en = 1'b1; end
          FN_SUB: begin d.cmd = ALU_SUB; d.ovf_en = 1'b1; end
          FN_AND: d.cmd = ALU_AND;
          FN_OR:  d.cmd = ALU_OR;
          FN_XOR: d.cmd = ALU_XOR;
          FN_SLT: d.cmd = ALU_SLT;
          default: begin d.illegal = 1'b1; d.dst = DST_NONE; end
        endcase
      end
      OP_ADDI: begin d.cmd = ALU_ADD; d.opb = OPB_SEXT; d.dst = DST_RT; d.ovf_en = 1'b1; end
      OP_ORI:  begin d.cmd = ALU_OR;  d.opb = OPB_ZEXT; d.dst = DST_RT; end
      OP_XORI: begin d.cmd = ALU_XOR; d.opb = OPB_ZEXT; d.dst = DST_RT; end
      OP_BEQ:  d.cmd = ALU_SUB;
      OP_JAL:  begin d.cmd = ALU_PC4; d.dst = DST_LINK; end
      default: d.illegal = 1'b1;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/exec_datapath_regfile.sv
// Register file: two combinational read ports, one write port, one debug read port.
// Register 0 is never written, so it always reads zero.
module regfile_param
  import exec_datapath_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int NREGS = 32,
  localparam int AW = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [AW-1:0]    ra_addr_i,
  output logic [WIDTH-1:0] ra_data_o,
  input  logic [AW-1:0]    rb_addr_i,
  output logic [WIDTH-1:0] rb_data_o,
  input  logic             we_i,
  input  logic [AW-1:0]    wa_i,
  input  logic [WIDTH-1:0] wd_i,
  input  logic [AW-1:0]    dbg_addr_i,
  output logic [WIDTH-1:0] dbg_data_o
);

  logic [WIDTH-1:0] regs_q [NREGS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else if (we_i && (wa_i != '0)) begin
      regs_q[wa_i] <= wd_i;
    end
  end

  assign ra_data_o  = regs_q[ra_addr_i];
  assign rb_data_o  = regs_q[rb_addr_i];
  assign dbg_data_o = regs_q[dbg_addr_i];

endmodule

// File: rtl/exec_datapath.sv
// Four-state (IDLE/DECODE/EXEC/WB) execute datapath for a MIPS-like instruction subset.
// Operands are latched in DECODE, the ALU result in EXEC, and the register write lands at the end of WB.
module exec_datapath
  import exec_datapath_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int NREGS = 32,
  localparam int AW = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             instr_valid,
  output logic             instr_ready,
  input  logic [31:0]      instr,
  input  logic [WIDTH-1:0] pc_in,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             overflow,
  output logic             result_valid,
  output logic             illegal,
  input  logic [AW-1:0]    dbg_addr,
  output logic [WIDTH-1:0] dbg_data
);

  state_e           state_q, state_d;
  logic [31:0]      ir_q;
  logic [WIDTH-1:0] pc_q, a_q, b_q, result_q;
  logic             zero_q, ovf_q, ill_q, we_q;
  logic [AW-1:0]    waddr_q;

  logic [WIDTH-1:0] rf_a, rf_b, opb, sum, diff, alu_res;
  logic             add_ovf, sub_ovf, slt, alu_ovf, alu_we;
  logic [AW-1:0]    alu_waddr;
  dec_t             dec;
  logic             unused_ir_bits;

  // Shamt and the upper register-index bits are carried in IR but never used.
  assign unused_ir_bits = ^ir_q;

  regfile_param #(.WIDTH(WIDTH), .NREGS(NREGS)) u_regfile (
    .clk        (clk),
    .rst_n      (rst_n),
    .ra_addr_i  (ir_q[21 +: AW]),
    .ra_data_o  (rf_a),
    .rb_addr_i  (ir_q[16 +: AW]),
    .rb_data_o  (rf_b),
    .we_i       (state_q == ST_WB && we_q),
    .wa_i       (waddr_q),
    .wd_i       (result_q),
    .dbg_addr_i (dbg_addr),
    .dbg_data_o (dbg_data)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (instr_valid) state_d = ST_DECODE;
      ST_DECODE: state_d = ST_EXEC;
      ST_EXEC:   state_d = ST_WB;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    dec = decode(ir_q[31:26], ir_q[5:0]);
    case (dec.opb)
      OPB_SEXT: opb = WIDTH'($signed(ir_q[15:0]));
      OPB_ZEXT: opb = WIDTH'(ir_q[15:0]);
      default:  opb = b_q;
    endcase
    sum     = a_q + opb;
    diff    = a_q - opb;
    add_ovf = (a_q[WIDTH-1] == opb[WIDTH-1]) && (sum[WIDTH-1] != a_q[WIDTH-1]);
    sub_ovf = (a_q[WIDTH-1] != opb[WIDTH-1]) && (diff[WIDTH-1] != a_q[WIDTH-1]);
    slt     = $signed(a_q) < $signed(opb);
    alu_res = '0;
    case (dec.cmd)
      ALU_ADD: alu_res = sum;
      ALU_SUB: alu_res = diff;
      ALU_AND: alu_res = a_q & opb;
      ALU_OR:  alu_res = a_q | opb;
      ALU_XOR: alu_res = a_q ^ opb;
      ALU_SLT: alu_res = WIDTH'(slt);
      ALU_PC4: alu_res = pc_q + WIDTH'(4);
      default: alu_res = '0;
    endcase
    // BEQ shares the SUB command but has ovf_en clear, so it never flags overflow.
    alu_ovf   = dec.ovf_en && ((dec.cmd == ALU_SUB) ? sub_ovf : add_ovf);
    alu_we    = 1'b1;
    alu_waddr = '0;
    case (dec.dst)
      DST_RD:   alu_waddr = ir_q[11 +: AW];
      DST_RT:   alu_waddr = ir_q[16 +: AW];
      DST_LINK: alu_waddr = AW'(NREGS - 1);
      default:  alu_we = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      ir_q     <= '0;
      pc_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
      ill_q    <= 1'b0;
      we_q     <= 1'b0;
      waddr_q  <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_IDLE && instr_valid) begin
        ir_q <= instr;
        pc_q <= pc_in;
      end
      if (state_q == ST_DECODE) begin
        a_q <= rf_a;
        b_q <= rf_b;
      end
      if (state_q == ST_EXEC) begin
        result_q <= alu_res;
        zero_q   <= (alu_res == '0);
        ovf_q    <= alu_ovf;
        ill_q    <= dec.illegal;
        we_q     <= alu_we;
        waddr_q  <= alu_waddr;
      end
    end
  end

  assign instr_ready  = (state_q == ST_IDLE);
  assign result_valid = (state_q == ST_WB);
  assign result       = result_q;
  assign zero         = zero_q;
  assign overflow     = ovf_q;
  assign illegal      = ill_q;

endmodule
